// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory controller: load/store operation codes,
// the default base address of the memory-mapped I/O region, and a helper
// that maps an operation code to its access size in bytes.
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Lowest address of the I/O region (addr[17:16] == 2'b11)
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Load/store operation codes carried on lsb_op
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    // Number of bytes moved by an operation; word-sized is the fallback
    function automatic logic [2:0] access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: access_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: access_size = 3'd2;
            default:              access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Arbitrates an instruction-fetch channel and a load/store channel onto a
// single byte-wide RAM/IO port, splitting each access into little-endian
// byte cycles.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global enable), clear (flush)
//   if_req/if_addr      -> if_done/if_data      : word fetch channel
//   lsb_req/lsb_wr/lsb_op/lsb_addr/lsb_wdata
//                       -> lsb_done/lsb_rdata   : load/store channel
//   mem_din/mem_dout/mem_a/mem_wr/io_buffer_full : byte-wide memory port
// ---------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [5:0]  lsb_op,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, size_q;
    logic [31:0] addr_q, wdata_q, asm_q;
    logic [5:0]  op_q;
    logic        is_lsb_q;
    logic        io_stall, last_write;
    logic [31:0] byte_addr, shifted, aligned, load_word;

    assign byte_addr  = addr_q + {29'd0, cnt};
    // An I/O store waits with its current byte held off the bus while the
    // I/O buffer reports full.
    assign io_stall   = (state == WRITE) && (addr_q >= IO_BASE) && io_buffer_full;
    assign last_write = !io_stall && (cnt == size_q - 3'd1);
    // Bytes arrive lowest first and are shifted in from the top, so after N
    // bytes the value sits in the upper N bytes of the register.
    assign shifted    = {mem_din, asm_q[31:8]};

    // Right-align the assembled bytes and apply sign extension for Lb/Lh.
    // Fetches are tagged as Lw at grant, so they pass through unchanged.
    always_comb begin
        aligned = shifted;
        case (size_q)
            3'd1:    aligned = {24'd0, shifted[31:24]};
            3'd2:    aligned = {16'd0, shifted[31:16]};
            default: aligned = shifted;
        endcase
        load_word = aligned;
        case (op_q)
            OP_LB:   load_word = {{24{aligned[7]}}, aligned[7:0]};
            OP_LH:   load_word = {{16{aligned[15]}}, aligned[15:0]};
            default: load_word = aligned;
        endcase
    end

    // Next-state logic. Grants happen only from IDLE with the load/store
    // channel winning; a READ needs one extra cycle after the last address
    // to capture the final byte, and DONE always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!clear) begin
                    if (lsb_req)     state_next = lsb_wr ? WRITE : READ;
                    else if (if_req) state_next = READ;
                end
            end
            READ: begin
                if (clear)               state_next = IDLE;
                else if (cnt == size_q)  state_next = DONE;
            end
            WRITE: begin
                if (last_write) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory port drive. Only active byte cycles put anything on the bus.
    always_comb begin
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        if (state == READ && cnt < size_q) begin
            mem_a = byte_addr;
        end else if (state == WRITE && !io_stall) begin
            mem_a    = byte_addr;
            mem_wr   = 1'b1;
            mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
        end
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in)     state <= IDLE;
        else if (rdy_in) state <= state_next;
    end

    // Datapath: latch the granted request, step the byte counter, collect
    // read bytes and register done/data on the way into DONE.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt       <= 3'd0;
            size_q    <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            asm_q     <= 32'd0;
            op_q      <= 6'd0;
            is_lsb_q  <= 1'b0;
            if_done   <= 1'b0;
            if_data   <= 32'd0;
            lsb_done  <= 1'b0;
            lsb_rdata <= 32'd0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    cnt   <= 3'd0;
                    asm_q <= 32'd0;
                    if (!clear && lsb_req) begin
                        addr_q   <= lsb_addr;
                        wdata_q  <= lsb_wdata;
                        op_q     <= lsb_op;
                        size_q   <= access_size(lsb_op);
                        is_lsb_q <= 1'b1;
                    end else if (!clear && if_req) begin
                        addr_q   <= if_addr;
                        wdata_q  <= 32'd0;
                        op_q     <= OP_LW;
                        size_q   <= 3'd4;
                        is_lsb_q <= 1'b0;
                    end
                end
                READ: begin
                    if (!clear) begin
                        cnt <= cnt + 3'd1;
                        if (cnt != 3'd0) asm_q <= shifted;
                        if (cnt == size_q) begin
                            if (is_lsb_q) begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= load_word;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= load_word;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        cnt <= cnt + 3'd1;
                        if (last_write) begin
                            lsb_done  <= 1'b1;
                            lsb_rdata <= addr_q;
                        end
                    end
                end
                DONE: begin
                    if_done  <= 1'b0;
                    lsb_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. A behavioural byte RAM (one-cycle read
// latency, I/O writes logged separately) sits on the memory port; expected
// results come from a shadow memory and byte-level access rules.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_wr, lsb_done;
    logic [5:0]  lsb_op;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int checks = 0;
    int fails  = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_op(lsb_op), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Environment RAM: 4 KiB aliased, I/O region writes go to a log instead
    logic [7:0]  ram [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = 12'd0;
    logic [7:0]  poke_data = 8'd0;
    int          io_writes = 0;
    logic [7:0]  io_last = 8'd0;

    always @(posedge clk_in) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (mem_wr && mem_a[17:16] == 2'b11) begin
            io_writes <= io_writes + 1;
            io_last   <= mem_dout;
        end else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    logic [31:0] exp_lsb_rdata = 32'd0;
    logic [31:0] exp_if_data   = 32'd0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        ref_mem[a] = d;
        step();
        poke_en = 1'b0;
    endtask

    function automatic int model_size(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    // Little-endian value of N bytes from the shadow memory, then extended
    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        logic [31:0] a;
        int n = model_size(op);
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v + (32'(ref_mem[a[11:0]]) << (8 * k));
        end
        if (op == OP_LB && v >= 32'd128)   v = v + 32'hFFFF_FF00;
        if (op == OP_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // One complete transaction with cycle-by-cycle bus expectations
    task automatic apply_stimulus(input string tag, input logic lsb, input logic wr,
                                  input logic [5:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] full_mask,
                                  input int clear_cyc, output int done_c,
                                  output logic [31:0] data);
        int n, k, exp_done, io_before;
        logic is_io, dn;
        logic [31:0] exp_data, a, b;
        n = lsb ? model_size(op) : 4;
        is_io = wr && (addr >= 32'h0003_0000);
        io_before = io_writes;
        exp_data = wr ? addr : model_load(lsb ? op : OP_LW, addr);
        k = 0; exp_done = -1; done_c = -1; data = 32'd0;
        step();
        if (lsb) begin
            lsb_req = 1'b1; lsb_wr = wr; lsb_op = op; lsb_addr = addr; lsb_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 0; c < 40; c++) begin
            if (c > 0) step();
            io_buffer_full = (c < 32) ? full_mask[c] : 1'b0;
            clear = (c == clear_cyc);
            sample();
            if (c == 0) check_output($sformatf("%s idle bus c0", tag), mem_a | 32'(mem_wr), 32'd0);
            if (c >= 1 && exp_done < 0) begin
                if (!wr) begin
                    check_output($sformatf("%s rd a c%0d", tag, c), mem_a, addr + 32'(c - 1));
                    check_output($sformatf("%s rd wr c%0d", tag, c), 32'(mem_wr), 32'd0);
                    if (c == n) exp_done = n + 2;
                end else if (is_io && io_buffer_full) begin
                    check_output($sformatf("%s stall c%0d", tag, c), mem_a | 32'(mem_wr), 32'd0);
                end else begin
                    b = (wdata >> (8 * k)) & 32'hFF;
                    check_output($sformatf("%s wr a c%0d", tag, c), mem_a, addr + 32'(k));
                    check_output($sformatf("%s wr byte c%0d", tag, c), {23'd0, mem_wr, mem_dout}, 32'h100 | b);
                    k++;
                    if (k == n) exp_done = c + 1;
                end
            end
            dn = lsb ? lsb_done : if_done;
            if (dn) begin
                done_c = c;
                data = lsb ? lsb_rdata : if_data;
                break;
            end
        end
        check_output($sformatf("%s done cycle", tag), 32'(done_c), 32'(exp_done));
        check_output($sformatf("%s data", tag), data, exp_data);
        step();
        if_req = 1'b0; lsb_req = 1'b0; clear = 1'b0; io_buffer_full = 1'b0;
        sample();
        check_output($sformatf("%s done width", tag), 32'(lsb ? lsb_done : if_done), 32'd0);
        if (lsb) exp_lsb_rdata = exp_data; else exp_if_data = exp_data;
        if (wr && is_io) begin
            check_output($sformatf("%s io count", tag), 32'(io_writes - io_before), 32'(n));
            check_output($sformatf("%s io byte", tag), 32'(io_last), (wdata >> (8 * (n - 1))) & 32'hFF);
        end else if (wr) begin
            for (int j = 0; j < n; j++) begin
                a = addr + 32'(j);
                ref_mem[a[11:0]] = 8'((wdata >> (8 * j)) & 32'hFF);
                check_output($sformatf("%s ram %0d", tag, j), 32'(ram[a[11:0]]), 32'(ref_mem[a[11:0]]));
            end
        end
    endtask

    initial begin
        int dc, ld_c, fd_c, seen;
        logic [31:0] d, wd, ad, fm;
        logic [5:0] op;
        logic [5:0] ops [0:7];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; lsb_req = 1'b0; lsb_wr = 1'b0;
        lsb_op = 6'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;

        // Reset state
        step(); step(); sample();
        check_output("rst if_done", 32'(if_done), 32'd0);
        check_output("rst lsb_done", 32'(lsb_done), 32'd0);
        check_output("rst if_data", if_data, 32'd0);
        check_output("rst lsb_rdata", lsb_rdata, 32'd0);
        check_output("rst bus", mem_a | 32'(mem_wr) | 32'(mem_dout), 32'd0);
        rst_in = 1'b1;

        // Preload RAM and shadow with random bytes, then directed values
        for (int i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));
        poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h200, 8'h80);

        // Word fetch and sign/zero-extended byte loads
        apply_stimulus("fetch100", 1'b0, 1'b0, OP_LW, 32'h100, 32'd0, 32'd0, -1, dc, d);
        check_output("fetch100 const", d, 32'h0000_0513);
        apply_stimulus("lb200", 1'b1, 1'b0, OP_LB, 32'h200, 32'd0, 32'd0, -1, dc, d);
        check_output("lb200 const", d, 32'hFFFF_FF80);
        apply_stimulus("lbu200", 1'b1, 1'b0, OP_LBU, 32'h200, 32'd0, 32'd0, -1, dc, d);
        check_output("lbu200 const", d, 32'h0000_0080);

        // Address wrap across 2^32
        apply_stimulus("lh_wrap", 1'b1, 1'b0, OP_LH, 32'hFFFF_FFFF, 32'd0, 32'd0, -1, dc, d);

        // Simultaneous requests: store wins, fetch follows after DONE
        step();
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_op = OP_SW; lsb_addr = 32'h300; lsb_wdata = 32'hAABB_CCDD;
        ld_c = -1; fd_c = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                step();
                if (ld_c >= 0) lsb_req = 1'b0;
            end
            sample();
            if (c >= 1 && c <= 4) begin
                check_output($sformatf("prio wr a c%0d", c), mem_a, 32'h300 + 32'(c - 1));
                check_output($sformatf("prio wr byte c%0d", c), {23'd0, mem_wr, mem_dout},
                             32'h100 | ((32'hAABB_CCDD >> (8 * (c - 1))) & 32'hFF));
            end
            if (c == 7) check_output("prio fetch a c7", mem_a, 32'h100);
            if (lsb_done && ld_c < 0) ld_c = c;
            if (if_done) begin fd_c = c; d = if_data; break; end
        end
        step(); if_req = 1'b0; lsb_req = 1'b0;
        check_output("prio lsb_done cycle", 32'(ld_c), 32'd5);
        check_output("prio if_done cycle", 32'(fd_c), 32'd12);
        check_output("prio if_data", d, model_load(OP_LW, 32'h100));
        for (int j = 0; j < 4; j++) ref_mem[12'h300 + 12'(j)] = 8'((32'hAABB_CCDD >> (8 * j)) & 32'hFF);
        exp_lsb_rdata = 32'h300;

        // I/O store held off the bus while the buffer is full
        apply_stimulus("sb_io", 1'b1, 1'b1, OP_SB, 32'h0003_0000, 32'h0000_005A, 32'h0000_000E, -1, dc, d);

        // Clear during a committed store is ignored
        apply_stimulus("sh_clear", 1'b1, 1'b1, OP_SH, 32'h310, 32'h0000_BEEF, 32'd0, 2, dc, d);

        // Clear during a load aborts it; controller is back in IDLE next cycle
        step();
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_op = OP_LW; lsb_addr = 32'h204;
        sample();
        step(); sample();
        check_output("abort a c1", mem_a, 32'h204);
        step(); clear = 1'b1; lsb_req = 1'b0; sample();
        step(); clear = 1'b0; if_req = 1'b1; if_addr = 32'h100; sample();
        check_output("abort no done c3", 32'(lsb_done), 32'd0);
        step(); sample();
        check_output("abort regrant a c4", mem_a, 32'h100);
        seen = 0; fd_c = -1;
        for (int c = 5; c < 15; c++) begin
            step(); sample();
            if (lsb_done) seen++;
            if (if_done) begin fd_c = c; break; end
        end
        step(); if_req = 1'b0;
        check_output("abort lsb_done count", 32'(seen), 32'd0);
        check_output("abort fetch done cycle", 32'(fd_c), 32'd9);
        check_output("abort lsb_rdata hold", lsb_rdata, exp_lsb_rdata);

        // Clear in IDLE suppresses the grant for that cycle
        step();
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_op = OP_LB; lsb_addr = 32'h200; clear = 1'b1;
        sample();
        step(); clear = 1'b0; sample();
        check_output("idleclr no grant c1", mem_a, 32'd0);
        step(); sample();
        check_output("idleclr grant a c2", mem_a, 32'h200);
        ld_c = -1;
        for (int c = 3; c < 12; c++) begin
            step(); sample();
            if (lsb_done) begin ld_c = c; d = lsb_rdata; break; end
        end
        step(); lsb_req = 1'b0;
        check_output("idleclr done cycle", 32'(ld_c), 32'd4);
        check_output("idleclr data", d, model_load(OP_LB, 32'h200));

        // rdy_in low freezes the access in place
        step();
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_op = OP_LH; lsb_addr = 32'h200;
        sample();
        step(); rdy_in = 1'b0; sample();
        check_output("rdy a c1", mem_a, 32'h200);
        step(); sample();
        check_output("rdy a c2", mem_a, 32'h200);
        step(); rdy_in = 1'b1; sample();
        check_output("rdy a c3", mem_a, 32'h200);
        step(); sample();
        check_output("rdy a c4", mem_a, 32'h201);
        ld_c = -1;
        for (int c = 5; c < 14; c++) begin
            step(); sample();
            if (lsb_done) begin ld_c = c; d = lsb_rdata; break; end
        end
        step(); lsb_req = 1'b0;
        check_output("rdy done cycle", 32'(ld_c), 32'd6);
        check_output("rdy data", d, model_load(OP_LH, 32'h200));

        // Randomized mix of fetches, loads and stores (some to I/O)
        for (int t = 0; t < 40; t++) begin
            op = ops[$urandom_range(0, 7)];
            ad = 32'($urandom_range(0, 4095));
            wd = $urandom;
            fm = $urandom & 32'h3E;
            if ($urandom_range(0, 3) == 0) begin
                apply_stimulus($sformatf("rnd%0d fetch", t), 1'b0, 1'b0, OP_LW, ad, 32'd0, 32'd0, -1, dc, d);
            end else if (op == OP_SB || op == OP_SH || op == OP_SW) begin
                if ($urandom_range(0, 2) == 0) ad = 32'h0003_0000 + 32'($urandom_range(0, 255));
                apply_stimulus($sformatf("rnd%0d st", t), 1'b1, 1'b1, op, ad, wd, fm, -1, dc, d);
            end else begin
                apply_stimulus($sformatf("rnd%0d ld", t), 1'b1, 1'b0, op, ad, 32'd0, 32'd0, -1, dc, d);
            end
        end

        // Reset in the middle of a word store
        step();
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_op = OP_SW; lsb_addr = 32'h340; lsb_wdata = 32'h1122_3344;
        sample();
        step(); sample();
        check_output("rstmid byte c1", {23'd0, mem_wr, mem_dout}, 32'h144);
        step(); rst_in = 1'b0; sample();
        check_output("rstmid a c2", mem_a, 32'h341);
        step(); rst_in = 1'b1; lsb_req = 1'b0; sample();
        check_output("rstmid bus c3", mem_a | 32'(mem_wr) | 32'(mem_dout), 32'd0);
        check_output("rstmid done c3", 32'(lsb_done) | 32'(if_done), 32'd0);
        check_output("rstmid lsb_rdata c3", lsb_rdata, 32'd0);
        check_output("rstmid if_data c3", if_data, 32'd0);
        ref_mem[12'h340] = 8'h44; ref_mem[12'h341] = 8'h33;
        check_output("rstmid ram 340", 32'(ram[12'h340]), 32'(ref_mem[12'h340]));
        check_output("rstmid ram 341", 32'(ram[12'h341]), 32'(ref_mem[12'h341]));
        check_output("rstmid ram 342", 32'(ram[12'h342]), 32'(ref_mem[12'h342]));
        step(); step(); sample();
        check_output("rstmid stays idle", mem_a | 32'(mem_wr) | 32'(lsb_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h00030000, meaning the lowest address of the memory-mapped I/O region (addr[17:16]==2'b11).
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset: synchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1, global enable; when low, all state and outputs hold.
REQ-005 SHALL have port clear, input, 1, mispredict flush.
REQ-006 SHALL have ports if_req (input, 1), if_addr (input, 32), if_done (output, 1), if_data (output, 32), forming the instruction-fetch word-read channel.
REQ-007 SHALL have ports lsb_req (input, 1), lsb_wr (input, 1, 0=load 1=store), lsb_op (input, 6, const.v codes Lb..Sw), lsb_addr (input, 32), lsb_wdata (input, 32), lsb_done (output, 1), lsb_rdata (output, 32), forming the load/store channel.
REQ-008 SHALL have ports mem_din (input, 8), mem_dout (output, 8), mem_a (output, 32), mem_wr (output, 1, 1=write) and io_buffer_full (input, 1), forming the byte-wide RAM/IO port.

Function
REQ-009 SHALL use states IDLE, READ, WRITE and DONE; transitions: IDLE->READ/WRITE on grant, READ/WRITE->DONE after the last byte, DONE->IDLE unconditionally.
REQ-010 SHALL grant in IDLE only, with lsb_req taking priority over if_req; a requester holds req and operands stable until it sees its done pulse.
REQ-011 SHALL use access size N = 1 for Lb/Lbu/Sb, 2 for Lh/Lhu/Sh, 4 for Lw/Sw and for fetch; bytes are little-endian at addr+0..addr+N-1, with address addition mod 2^32.
REQ-012 READ: request sampled in cycle 0; mem_a = addr+k, mem_wr=0 in cycles 1..N; the byte for the address presented in cycle c is sampled from mem_din at the end of cycle c+1; done pulses in cycle N+2 (fetch/Lw: cycle 6).
REQ-013 WRITE: mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr=1 in cycles 1..N; lsb_done pulses in cycle N+1.
REQ-014 A store with addr >= IO_BASE SHALL, while io_buffer_full=1, hold the pending byte off the bus (mem_wr=0, mem_a=0) and retry the same byte when io_buffer_full=0.
REQ-015 lsb_rdata SHALL be sign-extended for Lb/Lh and zero-extended for Lbu/Lhu; stores SHALL return lsb_rdata = addr.
REQ-016 done and data SHALL be registered; done is high exactly one cycle (DONE state), and data holds its value until the next done.
REQ-017 No grant SHALL occur in the DONE cycle, so a requester dropping req after done is never re-granted.
REQ-018 While not in an active byte cycle, mem_a=0, mem_wr=0 and mem_dout=0.
REQ-019 clear in READ (fetch or load) SHALL abort to IDLE next cycle with no done; clear in WRITE SHALL be ignored and the committed store completes with its done.
REQ-020 clear in IDLE/DONE SHALL suppress any grant that cycle.

Reset
REQ-021 When rst_in=0 at a clock edge, next state SHALL be IDLE with all outputs 0, the byte counter 0 and assembled data 0, regardless of rdy_in or an access in progress.
REQ-022 Reset mid-store SHALL abandon remaining bytes; already-written bytes stay in memory.

Structure
REQ-023 Op codes (Lb..Sw) and IO_BASE SHALL live in shared const.v; state encoding stays local.
REQ-024 SHALL be a single module; no sub-module is warranted.

Verification
REQ-025 Fetch if_addr=0x100 with bytes 13,05,00,00 -> if_done in cycle 6, if_data=0x00000513, mem_a 0x100..0x103 in cycles 1..4.
REQ-026 Lb at 0x200 reading 0x80 -> lsb_rdata=0xFFFFFF80 in cycle 3; Lbu at the same address -> 0x00000080.
REQ-027 if_req and lsb_req (Sw 0x300, data 0xAABBCCDD) both high in cycle 0 -> bytes DD,CC,BB,AA written in cycles 1..4, lsb_done in cycle 5, fetch granted in cycle 6 (after DONE), if_done in cycle 12.
REQ-028 Sb to 0x30000 with io_buffer_full high for cycles 1..3 -> mem_wr=0 in cycles 1..3, mem_wr=1 in cycle 4, lsb_done in cycle 5.
REQ-029 clear in cycle 2 of a Lw -> no lsb_done and IDLE in cycle 3; clear in cycle 2 of an Sh -> lsb_done in cycle 3.
REQ-030 rst_in=0 in cycle 2 of a Sw -> mem_wr=0, state IDLE and all outputs 0 in cycle 3.
